// File: rtl/prog_loader_pkg.sv
// Shared BIP definitions: instruction geometry, opcode map and the
// serial program loader's start command and state encoding.
package prog_loader_pkg;

  localparam int BIP_IBITS = 16;
  localparam int BIP_ADDR  = 11;
  localparam int BIP_DBITS = 8;
  localparam logic [7:0] BIP_START_BYTE = 8'hA5;

  // Opcode field occupies the top five bits of every instruction word.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;

  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    DONE    = 2'd3
  } loader_state_e;

  function automatic logic is_halt(input logic [BIP_IBITS-1:0] word);
    return word[OPC_MSB:OPC_LSB] == OP_HLT;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Serial program loader: assembles big-endian byte pairs from the UART
// into instruction words and writes them to program memory while holding the CPU in reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IBITS = BIP_IBITS,
  parameter int ADDR  = BIP_ADDR,
  parameter int DBITS = BIP_DBITS,
  parameter logic [DBITS-1:0] START_BYTE = BIP_START_BYTE
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DBITS-1:0] i_rx_data,
  input  logic             i_rx_done,
  output logic             o_wr_en,
  output logic [ADDR-1:0]  o_wr_addr,
  output logic [IBITS-1:0] o_wr_data,
  output logic             o_cpu_rst,
  output logic             o_done,
  output logic [ADDR:0]    o_count
);

  localparam logic [ADDR:0] COUNT_MAX = {1'b1, {ADDR{1'b0}}};

  loader_state_e    r_state;
  logic [DBITS-1:0] r_hi;
  logic [ADDR-1:0]  r_addr;
  logic             r_wr_en;
  logic [ADDR-1:0]  r_wr_addr;
  logic [IBITS-1:0] r_wr_data;
  logic             r_cpu_rst;
  logic             r_done;
  logic [ADDR:0]    r_count;

  logic [IBITS-1:0] w_word;
  logic             w_start;
  logic             w_halt;
  logic             w_last;

  assign w_word  = IBITS'({r_hi, i_rx_data});
  assign w_start = i_rx_done && (i_rx_data == START_BYTE);
  assign w_halt  = is_halt(BIP_IBITS'(w_word));
  // The top address is written once and then loading stops, so memory never wraps.
  assign w_last  = &r_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_hi      <= '0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_state   <= WAIT_HI;
            r_addr    <= '0;
            r_count   <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        WAIT_HI: begin
          if (i_rx_done) begin
            r_hi    <= i_rx_data;
            r_state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (i_rx_done) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_word;
            r_wr_addr <= r_addr;
            if (!w_last) begin
              r_addr <= r_addr + 1'b1;
            end
            if (r_count != COUNT_MAX) begin
              r_count <= r_count + 1'b1;
            end
            // Leaving for WAIT_HI here lets a byte arriving alongside the write strobe land as the next high byte.
            if (w_halt || w_last) begin
              r_state   <= DONE;
              r_cpu_rst <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_state <= WAIT_HI;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_cpu_rst = r_cpu_rst;
  assign o_done    = r_done;
  assign o_count   = r_count;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: byte sequences in,
// logged memory writes and status outputs compared against hand-computed values.
module tb_prog_loader;

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_done;
  logic        o_wr_en;
  logic [10:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_cpu_rst;
  logic        o_done;
  logic [11:0] o_count;

  int compared = 0;
  int mismatched = 0;

  logic [10:0] logAddr[$];
  logic [15:0] logData[$];

  prog_loader dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rx_data (i_rx_data),
    .i_rx_done (i_rx_done),
    .o_wr_en   (o_wr_en),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .o_cpu_rst (o_cpu_rst),
    .o_done    (o_done),
    .o_count   (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Every cycle with the write strobe high becomes one logged memory write.
  always @(negedge i_clk) begin
    if (o_wr_en) begin
      logAddr.push_back(o_wr_addr);
      logData.push_back(o_wr_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  task automatic applyBurst(input logic [7:0] bytes[$]);
    foreach (bytes[k]) begin
      @(negedge i_clk);
      i_rx_data = bytes[k];
      i_rx_done = 1'b1;
    end
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    int base;
    int badAddr;
    int badData;
    int zeroHits;
    logic [7:0] burst[$];

    i_rst = 1'b1;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    repeat (3) @(negedge i_clk);

    $display("[TB] reset state");
    checkOutput("rst_wr_en", o_wr_en, 0);
    checkOutput("rst_wr_addr", o_wr_addr, 0);
    checkOutput("rst_wr_data", o_wr_data, 0);
    checkOutput("rst_count", o_count, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_cpu_rst", o_cpu_rst, 1);
    i_rst = 1'b0;

    $display("[TB] stray bytes in IDLE");
    base = logAddr.size();
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    settle();
    checkOutput("idle_writes", logAddr.size() - base, 0);
    checkOutput("idle_cpu_rst", o_cpu_rst, 1);
    checkOutput("idle_done", o_done, 0);

    $display("[TB] basic load ending in HLT");
    base = logAddr.size();
    applyStimulus(8'hA5);
    applyStimulus(8'h08);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    settle();
    checkOutput("basic_writes", logAddr.size() - base, 2);
    if (logAddr.size() - base == 2) begin
      checkOutput("basic_addr0", logAddr[base], 11'd0);
      checkOutput("basic_data0", logData[base], 16'h0801);
      checkOutput("basic_addr1", logAddr[base+1], 11'd1);
      checkOutput("basic_data1", logData[base+1], 16'h0000);
    end
    checkOutput("basic_count", o_count, 2);
    checkOutput("basic_done", o_done, 1);
    checkOutput("basic_cpu_rst", o_cpu_rst, 0);

    $display("[TB] restart from DONE");
    base = logAddr.size();
    applyStimulus(8'hA5);
    settle();
    checkOutput("restart_done", o_done, 0);
    checkOutput("restart_cpu_rst", o_cpu_rst, 1);
    checkOutput("restart_count", o_count, 0);
    checkOutput("restart_hold_addr", o_wr_addr, 11'd1);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    settle();
    checkOutput("restart_writes", logAddr.size() - base, 1);
    if (logAddr.size() - base == 1) begin
      checkOutput("restart_addr", logAddr[base], 11'd0);
      checkOutput("restart_data", logData[base], 16'h0000);
    end
    checkOutput("restart_count2", o_count, 1);
    checkOutput("restart_done2", o_done, 1);

    $display("[TB] start byte as data");
    base = logAddr.size();
    applyStimulus(8'hA5);
    applyStimulus(8'hA5);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    settle();
    checkOutput("a5data_writes", logAddr.size() - base, 2);
    if (logAddr.size() - base == 2) begin
      checkOutput("a5data_addr0", logAddr[base], 11'd0);
      checkOutput("a5data_data0", logData[base], 16'hA5A5);
      checkOutput("a5data_addr1", logAddr[base+1], 11'd1);
      checkOutput("a5data_data1", logData[base+1], 16'h0000);
    end
    checkOutput("a5data_done", o_done, 1);

    $display("[TB] back-to-back bytes overlapping the write strobe");
    base = logAddr.size();
    burst = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00};
    applyBurst(burst);
    settle();
    checkOutput("b2b_writes", logAddr.size() - base, 3);
    if (logAddr.size() - base == 3) begin
      checkOutput("b2b_data0", logData[base], 16'h1234);
      checkOutput("b2b_addr1", logAddr[base+1], 11'd1);
      checkOutput("b2b_data1", logData[base+1], 16'h5678);
      checkOutput("b2b_addr2", logAddr[base+2], 11'd2);
      checkOutput("b2b_data2", logData[base+2], 16'h0000);
    end
    checkOutput("b2b_count", o_count, 3);
    checkOutput("b2b_done", o_done, 1);

    $display("[TB] asynchronous reset mid-word");
    applyStimulus(8'hA5);
    applyStimulus(8'h08);
    #3 i_rst = 1'b1;
    #1;
    checkOutput("arst_wr_addr", o_wr_addr, 0);
    checkOutput("arst_wr_en", o_wr_en, 0);
    checkOutput("arst_count", o_count, 0);
    checkOutput("arst_cpu_rst", o_cpu_rst, 1);
    checkOutput("arst_done", o_done, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    base = logAddr.size();
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    settle();
    checkOutput("arst_writes", logAddr.size() - base, 0);
    checkOutput("arst_cpu_rst2", o_cpu_rst, 1);

    $display("[TB] fill entire program memory");
    base = logAddr.size();
    applyStimulus(8'hA5);
    @(negedge i_clk);
    i_rx_done = 1'b1;
    for (int w = 0; w < 2048; w++) begin
      i_rx_data = 8'h10;
      @(negedge i_clk);
      i_rx_data = 8'h01;
      @(negedge i_clk);
    end
    i_rx_done = 1'b0;
    settle();
    checkOutput("fill_writes", logAddr.size() - base, 2048);
    if (logAddr.size() - base == 2048) begin
      badAddr = 0;
      badData = 0;
      zeroHits = 0;
      for (int k = 0; k < 2048; k++) begin
        if (logAddr[base+k] != 11'(k)) badAddr++;
        if (logData[base+k] != 16'h1001) badData++;
        if (logAddr[base+k] == 11'd0) zeroHits++;
      end
      checkOutput("fill_addr_seq", badAddr, 0);
      checkOutput("fill_data", badData, 0);
      checkOutput("fill_zero_once", zeroHits, 1);
      checkOutput("fill_last_addr", logAddr[base+2047], 11'd2047);
    end
    checkOutput("fill_count", o_count, 12'd2048);
    checkOutput("fill_done", o_done, 1);
    checkOutput("fill_cpu_rst", o_cpu_rst, 0);
    base = logAddr.size();
    applyStimulus(8'h10);
    applyStimulus(8'h01);
    settle();
    checkOutput("fill_after_writes", logAddr.size() - base, 0);
    checkOutput("fill_hold_addr", o_wr_addr, 11'd2047);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL have parameter IBITS, default 16, meaning instruction width.
REQ-002 The module SHALL have parameter ADDR, default 11, meaning program memory address width.
REQ-003 The module SHALL have parameter DBITS, default 8, meaning UART byte width.
REQ-004 The module SHALL have parameter START_BYTE, default 8'hA5, meaning load-start command byte.
REQ-005 The module SHALL have port i_clk, input, 1, meaning the single clock.
REQ-006 The module SHALL have port i_rst, input, 1, meaning reset; asynchronous, active-high.
REQ-007 The module SHALL have port i_rx_data, input, DBITS, meaning received UART byte.
REQ-008 The module SHALL have port i_rx_done, input, 1, meaning a one-cycle pulse marking i_rx_data valid.
REQ-009 The module SHALL have port o_wr_en, output, 1, meaning program memory write strobe.
REQ-010 The module SHALL have port o_wr_addr, output, ADDR, meaning program memory write address.
REQ-011 The module SHALL have port o_wr_data, output, IBITS, meaning instruction word to write.
REQ-012 The module SHALL have port o_cpu_rst, output, 1, meaning hold the BIP control/PC in reset.
REQ-013 The module SHALL have port o_done, output, 1, meaning the program is loaded.
REQ-014 The module SHALL have port o_count, output, ADDR+1, meaning the number of words written.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT_HI, WAIT_LO and DONE.
REQ-016 In IDLE, i_rx_done with i_rx_data==START_BYTE SHALL go to WAIT_HI and clear o_count and the address counter; any other byte SHALL be ignored.
REQ-017 In WAIT_HI, i_rx_done SHALL latch i_rx_data into word bits [15:8] and go to WAIT_LO.
REQ-018 In WAIT_LO, i_rx_done SHALL form the word from the latched high byte and i_rx_data as bits [7:0].
REQ-019 On that WAIT_LO completion, the next cycle SHALL present o_wr_en=1 for exactly one cycle, with o_wr_data=word and o_wr_addr=current address.
REQ-020 The address counter and o_count SHALL increment by 1 in the same cycle that o_wr_en is high.
REQ-021 If word[15:11]==5'b00000 (HLT opcode), the FSM SHALL go to DONE after the write; otherwise it SHALL go to WAIT_HI.
REQ-022 If the write address is 2^ADDR-1 (2047), the FSM SHALL go to DONE after the write regardless of opcode; the address SHALL NOT wrap to 0 and overwrite.
REQ-023 o_count SHALL saturate at 2^ADDR (2048).
REQ-024 o_cpu_rst SHALL be 1 in IDLE, WAIT_HI and WAIT_LO, and 0 in DONE.
REQ-025 o_done SHALL be 1 only in DONE.
REQ-026 In DONE, i_rx_done with START_BYTE SHALL restart loading: go to WAIT_HI, clear the counters, raise o_cpu_rst and drop o_done; other bytes SHALL be ignored.
REQ-027 START_BYTE received in WAIT_HI or WAIT_LO SHALL be treated as data, not as a restart.
REQ-028 o_wr_addr and o_wr_data SHALL hold their last values when o_wr_en=0.
REQ-029 i_rx_done arriving in the same cycle as o_wr_en SHALL be accepted as the next high byte, with no byte dropped.

Reset
REQ-030 On i_rst=1, the state SHALL be IDLE, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_count=0, o_done=0 and o_cpu_rst=1, asynchronously.
REQ-031 Reset asserted mid-load SHALL abandon the partial word and require a new START_BYTE.

Structure
REQ-032 IBITS, ADDR, the opcode field position [15:11] and the HLT opcode 5'b00000 SHALL live in the shared BIP package with the decoder opcodes; START_BYTE SHALL live there too.
REQ-033 The block SHALL be a single module with no sub-module; the FSM, byte latch and counter are inline.
REQ-034 All outputs SHALL be driven from registers.

Verification
REQ-035 Reset, then send bytes A5,08,01,00,00 -> writes 16'h0801@0 and 16'h0000@1; o_count=2; o_done=1; o_cpu_rst=0.
REQ-036 Send bytes 12,34 in IDLE -> no write; state remains IDLE; o_cpu_rst=1.
REQ-037 Send A5 followed by 2048 non-HLT words (e.g., 16'h1001) -> last write at address 2047; DONE entered; o_count=2048; no write at address 0 afterwards.
REQ-038 Send A5,A5,A5,00,00 -> write 16'hA5A5@0, then 16'h0000@1, then DONE.
REQ-039 Assert i_rst after A5,08 (mid-word) -> outputs at reset values; a following 00,00 causes no write.
REQ-040 In DONE, send A5,00,00 -> o_done drops, o_cpu_rst rises, write 0000@0, o_count=1, DONE re-entered.
